// File: rtl/adbg_cpu_access_sched.sv
// Debug-bus access scheduler: walks a core mask lowest-first, one strobe/response per core.
// Optional ack timeout is built only when ADBG_SCHED_TIMEOUT_EN is defined.
module adbg_cpu_access_sched #(
  parameter int unsigned NB_CORES       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CORE_IDX_W    = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
  input  logic                               cpu_clk_i,
  input  logic                               cpu_rst_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [NB_CORES-1:0]                req_core_mask_i,
  input  logic [15:0]                        req_addr_i,
  input  logic [31:0]                        req_wdata_i,
  input  logic                               req_we_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [31:0]                        rsp_rdata_o,
  output logic                               rsp_err_o,
  output logic [CORE_IDX_W-1:0]              rsp_core_o,
  output logic                               rsp_last_o,
  output logic [NB_CORES-1:0][15:0]          cpu_addr_o,
  output logic [NB_CORES-1:0][31:0]          cpu_data_o,
  output logic [NB_CORES-1:0]                cpu_we_o,
  output logic [NB_CORES-1:0]                cpu_stb_o,
  input  logic [NB_CORES-1:0][31:0]          cpu_data_i,
  input  logic [NB_CORES-1:0]                cpu_ack_i
);

  if (NB_CORES < 1 || NB_CORES > 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("adbg_cpu_access_sched: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                r_state;
  logic [NB_CORES-1:0]   r_pend;
  logic [NB_CORES-1:0]   r_stb;
  logic [CORE_IDX_W-1:0] r_idx;
  logic [15:0]           r_addr;
  logic [31:0]           r_wdata;
  logic                  r_we;
  logic                  r_rsp_valid;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  r_last;
  logic [CORE_IDX_W-1:0] r_core;

  logic [NB_CORES-1:0]   w_cur;
  logic [NB_CORES-1:0]   w_rest;
  logic                  w_timeout;

  function automatic logic [CORE_IDX_W-1:0] f_lowest(input logic [NB_CORES-1:0] m);
    f_lowest = '0;
    for (int unsigned i = NB_CORES; i > 0; i--) begin
      if (m[CORE_IDX_W'(i - 1)]) f_lowest = CORE_IDX_W'(i - 1);
    end
  endfunction

  assign w_cur  = NB_CORES'(1) << r_idx;
  assign w_rest = r_pend & ~w_cur;

`ifdef ADBG_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Counts ISSUE cycles; the TIMEOUT_CYCLES-th cycle without ack aborts.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i || r_state != ISSUE) r_cnt <= '0;
    else                               r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_stb       <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_last      <= 1'b0;
      r_core      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_we    <= req_we_i;
            r_pend  <= req_core_mask_i;
            if (req_core_mask_i == '0) begin
              r_rsp_valid <= 1'b1;
              r_err       <= 1'b1;
              r_last      <= 1'b1;
              r_core      <= '0;
              r_rdata     <= '0;
              r_state     <= RESP;
            end else begin
              r_idx   <= f_lowest(req_core_mask_i);
              r_stb   <= NB_CORES'(1) << f_lowest(req_core_mask_i);
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Ack is checked before the timeout so a same-cycle ack completes normally.
          if (cpu_ack_i[r_idx] || w_timeout) begin
            r_rdata     <= (cpu_ack_i[r_idx] && !r_we) ? cpu_data_i[r_idx] : '0;
            r_err       <= !cpu_ack_i[r_idx];
            r_stb       <= '0;
            r_rsp_valid <= 1'b1;
            r_core      <= r_idx;
            r_last      <= (w_rest == '0);
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_pend      <= w_rest;
            if (w_rest != '0) begin
              r_idx   <= f_lowest(w_rest);
              r_stb   <= NB_CORES'(1) << f_lowest(w_rest);
              r_state <= ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign rsp_core_o  = r_core;
  assign rsp_last_o  = r_last;
  assign cpu_stb_o   = r_stb;
  assign cpu_we_o    = {NB_CORES{r_we}};

  for (genvar g = 0; g < NB_CORES; g++) begin : g_lane
    assign cpu_addr_o[g] = r_addr;
    assign cpu_data_o[g] = r_wdata;
  end

endmodule

// File: tb/tb_adbg_cpu_access_sched.sv
// Scoreboard bench for adbg_cpu_access_sched: behavioural core models plus per-request expected queue.
module tb_adbg_cpu_access_sched;
  localparam int unsigned NB = 4;
  localparam int unsigned TO = 8;

  logic                 clk = 1'b0;
  logic                 cpu_rst_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [NB-1:0]        req_core_mask_i;
  logic [15:0]          req_addr_i;
  logic [31:0]          req_wdata_i;
  logic                 req_we_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [31:0]          rsp_rdata_o;
  logic                 rsp_err_o;
  logic [1:0]           rsp_core_o;
  logic                 rsp_last_o;
  logic [NB-1:0][15:0]  cpu_addr_o;
  logic [NB-1:0][31:0]  cpu_data_o;
  logic [NB-1:0]        cpu_we_o;
  logic [NB-1:0]        cpu_stb_o;
  logic [NB-1:0][31:0]  cpu_data_i;
  logic [NB-1:0]        cpu_ack_i;

  always #5 clk = ~clk;

  adbg_cpu_access_sched #(.NB_CORES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .cpu_clk_i(clk), .cpu_rst_i(cpu_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_core_mask_i(req_core_mask_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_core_o(rsp_core_o), .rsp_last_o(rsp_last_o),
    .cpu_addr_o(cpu_addr_o), .cpu_data_o(cpu_data_o), .cpu_we_o(cpu_we_o),
    .cpu_stb_o(cpu_stb_o), .cpu_data_i(cpu_data_i), .cpu_ack_i(cpu_ack_i)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        last;
    logic [1:0]  core;
  } rsp_t;

  rsp_t          exp_q[$];
  int unsigned   n_chk = 0;
  int unsigned   n_fail = 0;
  logic [31:0]   core_mem[NB][16];
  logic [31:0]   ref_mem[NB][16];
  int unsigned   delay_cfg[NB];
  logic [15:0]   cur_addr = '0;
  logic [31:0]   cur_wdata = '0;
  logic          cur_we = 1'b0;
  logic [NB-1:0] cur_mask = '0;
  bit            flush = 1'b0;
  int unsigned   rdy_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core bus models: ack after delay_cfg[c] strobe cycles (0 = never), memory-backed reads.
  initial begin
    int unsigned   cyc[NB];
    bit            active[NB];
    logic [NB-1:0] ack_n;
    logic [NB-1:0][31:0] data_n;
    for (int c = 0; c < NB; c++) begin cyc[c] = 0; active[c] = 1'b0; end
    cpu_ack_i = '0;
    cpu_data_i = '0;
    forever begin
      @(negedge clk);
      ack_n = NB'($urandom) & ~cpu_stb_o;
      for (int c = 0; c < NB; c++) data_n[c] = $urandom;
      if (cpu_stb_o != '0)
        check("stb_legal", ((cpu_stb_o & (cpu_stb_o - 1'b1)) == '0) && ((cpu_stb_o & ~cur_mask) == '0), 1);
      for (int c = 0; c < NB; c++) begin
        if (cpu_stb_o[c]) begin
          if (!active[c]) begin
            active[c] = 1'b1;
            cyc[c] = 0;
            check("lane_addr", cpu_addr_o, {NB{cur_addr}});
            check("lane_wdata", cpu_data_o, {NB{cur_wdata}});
            check("lane_we", cpu_we_o, {NB{cur_we}});
          end
          cyc[c]++;
          if (delay_cfg[c] != 0 && cyc[c] == delay_cfg[c]) begin
            ack_n[c] = 1'b1;
            if (cpu_we_o[c]) core_mem[c][cpu_addr_o[c][3:0]] = cpu_data_o[c];
            else             data_n[c] = core_mem[c][cpu_addr_o[c][3:0]];
          end
        end else if (active[c]) begin
          active[c] = 1'b0;
          if (!flush) check("stb_len", cyc[c], (delay_cfg[c] == 0) ? TO : delay_cfg[c]);
        end
      end
      cpu_ack_i = ack_n;
      cpu_data_i = data_n;
    end
  end

  // Response monitor: drives rsp_ready, pops and compares on each handshake.
  initial begin
    rsp_t        cur, prev, e;
    bit          hold = 1'b0;
    bit          idle_chk = 1'b0;
    int unsigned wcnt = 0;
    prev = '0;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        check("idle_gap", {req_ready_o, rsp_valid_o}, 2'b10);
        idle_chk = 1'b0;
      end
      if (rsp_valid_o) begin
        cur = '{rsp_rdata_o, rsp_err_o, rsp_last_o, rsp_core_o};
        check("no_stb_in_resp", cpu_stb_o, 0);
        if (hold) check("rsp_stable", cur, prev);
        if (rdy_mode == 1) begin
          if (wcnt < 2) begin rsp_ready_i = 1'b0; wcnt++; end
          else begin rsp_ready_i = 1'b1; wcnt = 0; end
        end else begin
          rsp_ready_i = ($urandom_range(0, 2) != 0);
        end
        if (rsp_ready_i) begin
          hold = 1'b0;
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: got %0h expected none", cur);
          end else begin
            n_chk--;
            e = exp_q.pop_front();
            check("rsp", cur, e);
            if (e.last) idle_chk = 1'b1;
          end
        end else begin
          hold = 1'b1;
          prev = cur;
        end
      end else begin
        hold = 1'b0;
        rsp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic do_req(input logic [NB-1:0] m, input logic [15:0] a, input logic [31:0] wd, input logic we);
    int unsigned guard = 0;
    rsp_t e;
    @(negedge clk);
    while (!req_ready_o && guard < 2000) begin @(negedge clk); guard++; end
    check("req_ready_wait", req_ready_o, 1);
    cur_addr = a; cur_wdata = wd; cur_we = we; cur_mask = m;
    if (m == '0) begin
      e = '{32'h0, 1'b1, 1'b1, 2'd0};
      exp_q.push_back(e);
    end else begin
      for (int c = 0; c < NB; c++) begin
        if (m[c]) begin
          e.core = 2'(c);
          e.last = ((m >> (c + 1)) == '0);
          if (delay_cfg[c] == 0) begin
`ifdef ADBG_SCHED_TIMEOUT_EN
            e.rdata = '0; e.err = 1'b1;
            exp_q.push_back(e);
`else
            break;
`endif
          end else begin
            e.err = 1'b0;
            e.rdata = we ? 32'h0 : ref_mem[c][a[3:0]];
            if (we) ref_mem[c][a[3:0]] = wd;
            exp_q.push_back(e);
          end
        end
      end
    end
    req_valid_i = 1'b1; req_core_mask_i = m; req_addr_i = a; req_wdata_i = wd; req_we_i = we;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_core_mask_i = NB'($urandom); req_addr_i = 16'($urandom); req_wdata_i = $urandom; req_we_i = 1'($urandom);
    check("ready_low", req_ready_o, 0);
    check("first_stb", cpu_stb_o, m & (~m + 1'b1));
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && req_ready_o && !rsp_valid_o) && guard < 3000) begin
      @(negedge clk); guard++;
    end
    check("drain", (exp_q.size() == 0) && req_ready_o, 1);
  endtask

  task automatic do_reset();
    flush = 1'b1;
    @(negedge clk); cpu_rst_i = 1'b1;
    @(negedge clk);
    check("rst_stb", cpu_stb_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    cpu_rst_i = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_ok;
    int unsigned guard;
    logic [NB-1:0] m;
    cpu_rst_i = 1'b1;
    req_valid_i = 1'b0; req_core_mask_i = '0; req_addr_i = '0; req_wdata_i = '0; req_we_i = 1'b0;
    for (int c = 0; c < NB; c++) begin
      delay_cfg[c] = 1;
      for (int i = 0; i < 16; i++) begin
        core_mem[c][i] = $urandom;
        ref_mem[c][i] = core_mem[c][i];
      end
    end
    repeat (3) @(negedge clk);
    check("rst_req_ready0", req_ready_o, 1);
    check("rst_outs0", {rsp_valid_o, rsp_err_o, rsp_last_o, rsp_core_o, cpu_stb_o, cpu_we_o}, 0);
    check("rst_rdata0", rsp_rdata_o, 0);
    check("rst_addr0", cpu_addr_o, 0);
    check("rst_data0", cpu_data_o, 0);
    cpu_rst_i = 1'b0;

    // single write to core 2, ack on the third strobe cycle
    delay_cfg[2] = 3;
    do_req(4'b0100, 16'h0010, 32'hDEADBEEF, 1'b1);
    wait_idle();
    check("lanes_hold", cpu_data_o, {NB{32'hDEADBEEF}});

    // read broadcast with slow response consumer
    core_mem[0][0] = 32'h11; ref_mem[0][0] = 32'h11;
    core_mem[1][0] = 32'h22; ref_mem[1][0] = 32'h22;
    core_mem[3][0] = 32'h88; ref_mem[3][0] = 32'h88;
    delay_cfg[0] = 1; delay_cfg[1] = 2; delay_cfg[3] = 4;
    rdy_mode = 1;
    do_req(4'b1011, 16'h0020, 32'h0, 1'b0);
    wait_idle();

    // empty mask
    do_req(4'b0000, 16'h0033, 32'h12345678, 1'b0);
    wait_idle();
    rdy_mode = 0;

    // ack on the last permitted cycle
    core_mem[3][5] = 32'hCAFE0001; ref_mem[3][5] = 32'hCAFE0001;
    delay_cfg[3] = TO;
    do_req(4'b1000, 16'h0005, 32'h0, 1'b0);
    wait_idle();

    // core 1 never acks
    delay_cfg[1] = 0;
    do_req(4'b0010, 16'h0031, 32'h0, 1'b0);
`ifdef ADBG_SCHED_TIMEOUT_EN
    wait_idle();
`else
    n_ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cpu_stb_o == 4'b0010 && !rsp_valid_o) n_ok++;
    end
    check("hung_hold", n_ok, 1000);
    do_reset();
`endif
    delay_cfg[1] = 2;

    // reset in the middle of a three-core broadcast
    delay_cfg[0] = 2; delay_cfg[2] = 0; delay_cfg[3] = 2;
    do_req(4'b1101, 16'h0042, 32'h0, 1'b0);
    guard = 0;
    while (cpu_stb_o != 4'b0100 && guard < 500) begin @(negedge clk); guard++; end
    check("reach_core2", cpu_stb_o, 4'b0100);
    do_reset();
    delay_cfg[2] = 1;
    do_req(4'b0001, 16'h0007, 32'h0, 1'b0);
    wait_idle();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      m = NB'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      for (int c = 0; c < NB; c++) delay_cfg[c] = $urandom_range(1, TO);
      rdy_mode = $urandom_range(0, 1);
      do_req(m, 16'($urandom), $urandom, 1'($urandom));
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
